down_counter_timer: RTL
=======================

// Module: down_counter_timer
// PURPOSE
//  Loadable down-counter/timer; complement of the 4-bit up counter. Counts a loaded value
//  down to zero on enabled cycles and flags terminal count. Used for interframe-gap,
//  backoff and timeout timing in the Ethernet datapath. One-shot or auto-reload mode.
// PARAMETERS
//  WIDTH   4   counter width in bits (legal 2..16)
// PORTS
//  clock        in   1      clock; all logic on posedge clock
//  reset        in   1      synchronous, active-high reset
//  enable       in   1      count-enable; decrement only on cycles with enable=1
//  load         in   1      load strobe; captures load_value (any state)
//  load_value   in   WIDTH  start/reload value
//  auto_reload  in   1      1: reload on expiry and keep running; 0: one-shot
//  counter_out  out  WIDTH  current count (registered)
//  busy         out  1      1 while state==RUN (registered)
//  zero         out  1      counter_out==0 (combinational from register)
//  tc_pulse     out  1      1-cycle pulse, registered, in the cycle after expiry edge
// BEHAVIOUR
//  - States: IDLE, RUN, EXPIRED (2-bit encoding, see package).
//  - Reset (sampled on posedge): state=IDLE, counter_out=0, reload_reg=0, busy=0, tc_pulse=0.
//    Reset mid-RUN aborts immediately; no tc_pulse generated.
//  - load=1 (any state, highest priority after reset): counter_out<=load_value,
//    reload_reg<=load_value, tc_pulse<=0; next state RUN if load_value!=0,
//    else EXPIRED (load of 0 never pulses tc_pulse). Same-cycle enable ignored.
//  - RUN, enable=1, counter_out>1: counter_out<=counter_out-1.
//  - RUN, enable=1, counter_out==1 (expiry): tc_pulse<=1;
//      auto_reload=1: counter_out<=reload_reg, stay RUN (period = reload_reg enabled cycles);
//      auto_reload=0: counter_out<=0, state<=EXPIRED.
//  - RUN, enable=0: hold all; tc_pulse<=0.
//  - IDLE/EXPIRED without load: hold; counter_out never decrements below 0 (no wrap to all-ones).
//  - auto_reload sampled only at the expiry cycle; may change freely otherwise.
//  - Load coincident with expiry: load wins, no tc_pulse.
//  - tc_pulse is high for exactly one cycle per expiry, even if enable stays high.
//  - Latency: load -> counter_out valid 1 cycle; expiry edge -> tc_pulse 1 cycle
//    (tc_pulse and counter_out==0/reload value assert on the same clock).
//  - All arithmetic unsigned WIDTH bits; max count 2**WIDTH-1.
// STRUCTURE
//  - Shared package: state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_EXPIRED=2'd2
//    (2'd3 illegal -> next state IDLE, counter_out=0).
//  - Single module; next-state/next-count combinational block + one registered block.
//    No sub-module warranted.
// TESTING
//  1. reset=1 2 cycles then release -> counter_out=0, busy=0, zero=1, tc_pulse=0, state IDLE.
//  2. load 4'd3, auto_reload=0, enable=1 constant -> counter_out 3,2,1,0; tc_pulse=1 exactly on
//     cycle counter_out hits 0; busy falls same cycle; counter stays 0 for 5 more cycles.
//  3. load 4'd2, auto_reload=1, enable=1 for 8 cycles -> sequence 2,1,2,1,2,1,2,1;
//     tc_pulse on each return to 2 (every 2 cycles).
//  4. load 4'd5, toggle enable 1,0,1,0 -> count 5,4,4,3,3; no tc_pulse; busy=1 throughout.
//  5. load 4'd1 with enable=1, then load 4'd9 on the expiry cycle -> counter_out=9, tc_pulse=0,
//     busy=1; assert reset during RUN at count 6 -> next cycle counter_out=0, busy=0, no tc_pulse.
//  6. load 4'd0 -> counter_out=0, state EXPIRED, tc_pulse never asserts; load 4'hF then
//     15 enabled cycles -> tc_pulse once, counter_out=0, no wrap to 4'hF.

Source files
------------

// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the loadable down-counter/timer: state encoding and state type.
package down_counter_timer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_RUN     = ST_RUN,
        S_EXPIRED = ST_EXPIRED
    } state_t;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with terminal-count pulse and optional auto-reload,
// used for interframe-gap, backoff and timeout timing.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] counter_out,
    output logic             busy,
    output logic             zero,
    output logic             tc_pulse
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    // Next-state logic: load beats everything (including a coincident expiry),
    // and tc only rises on the single cycle that follows an expiry edge.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? S_RUN : S_EXPIRED;
        end else begin
            case (state_q)
                S_IDLE, S_EXPIRED: begin
                    state_d = state_q;
                end
                S_RUN: begin
                    if (enable) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = S_EXPIRED;
                            end
                        end else begin
                            // A zero count while running cannot time out again.
                            state_d = S_EXPIRED;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign counter_out = count_q;
    assign busy        = (state_q == S_RUN);
    assign zero        = (count_q == '0);
    assign tc_pulse    = tc_q;

endmodule
